// File: rtl/guess_checker.sv
// Five-letter word checker: marks each guess letter green/yellow/gray against a target word,
// one green pass then one yellow position per cycle, and keeps per-game row/win/game-over state.
module guess_checker #(
    parameter int unsigned MAX_GUESSES = 6
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        start,
    input  logic [24:0] guess,
    input  logic [24:0] target,
    output logic [9:0]  result,
    output logic        done,
    output logic        busy,
    output logic [2:0]  row,
    output logic        win,
    output logic        game_over
);
    localparam int unsigned LETTERS = 5;
    localparam int unsigned CODE_W  = 5;
    localparam int unsigned WORD_W  = LETTERS * CODE_W;
    localparam int unsigned RES_W   = 2 * LETTERS;
    localparam int unsigned ROW_W   = 3;
    localparam int unsigned IDX_W   = 3;

    localparam logic [1:0]       COL_YELLOW = 2'b01;
    localparam logic [1:0]       COL_GREEN  = 2'b10;
    localparam logic [ROW_W-1:0] ROW_MAX    = ROW_W'(MAX_GUESSES);
    localparam logic [RES_W-1:0] ALL_GREEN  = {LETTERS{COL_GREEN}};

    typedef enum logic [1:0] {IDLE, GREEN, YELLOW, DONE} state_t;

    state_t              state_q, state_d;
    logic [WORD_W-1:0]   guess_q, guess_d;
    logic [WORD_W-1:0]   target_q, target_d;
    logic [RES_W-1:0]    result_q, result_d;
    logic [LETTERS-1:0]  used_q, used_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [ROW_W-1:0]    row_q, row_d;
    logic                win_q, win_d;
    logic                game_over_q, game_over_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                start_q, start_d;

    logic [CODE_W-1:0]   g_let [LETTERS];
    logic [CODE_W-1:0]   t_let [LETTERS];
    logic [CODE_W-1:0]   cur_let;
    logic                cur_green;
    logic                hit;
    logic [IDX_W-1:0]    hit_j;
    logic                all_green;

    // Letter unpacking and lowest-unused-target search for the current yellow index
    always_comb begin
        for (int i = 0; i < LETTERS; i++) begin
            g_let[i] = guess_q[CODE_W*i +: CODE_W];
            t_let[i] = target_q[CODE_W*i +: CODE_W];
        end
        cur_let   = g_let[0];
        cur_green = 1'b0;
        for (int i = 0; i < LETTERS; i++) begin
            if (IDX_W'(i) == idx_q) begin
                cur_let   = g_let[i];
                cur_green = result_q[2*i+1];
            end
        end
        hit   = 1'b0;
        hit_j = '0;
        for (int j = LETTERS - 1; j >= 0; j--) begin
            if (!used_q[j] && (t_let[j] == cur_let)) begin
                hit   = 1'b1;
                hit_j = IDX_W'(j);
            end
        end
        all_green = (result_q == ALL_GREEN);
    end

    // Next-state and datapath; start is edge-qualified so a held level launches one check
    always_comb begin
        state_d     = state_q;
        guess_d     = guess_q;
        target_d    = target_q;
        result_d    = result_q;
        used_d      = used_q;
        idx_d       = idx_q;
        row_d       = row_q;
        win_d       = win_q;
        game_over_d = game_over_q;
        busy_d      = 1'b0;
        done_d      = 1'b0;
        start_d     = start;

        case (state_q)
            IDLE: begin
                if (start && !start_q && !game_over_q) begin
                    guess_d  = guess;
                    target_d = target;
                    used_d   = '0;
                    result_d = '0;
                    busy_d   = 1'b1;
                    state_d  = GREEN;
                end
            end
            GREEN: begin
                for (int i = 0; i < LETTERS; i++) begin
                    if (g_let[i] == t_let[i]) begin
                        result_d[2*i +: 2] = COL_GREEN;
                        used_d[i]          = 1'b1;
                    end
                end
                idx_d   = '0;
                busy_d  = 1'b1;
                state_d = YELLOW;
            end
            YELLOW: begin
                busy_d = 1'b1;
                idx_d  = idx_q + IDX_W'(1);
                if (!cur_green && hit) begin
                    for (int i = 0; i < LETTERS; i++) begin
                        if (IDX_W'(i) == idx_q) result_d[2*i +: 2] = COL_YELLOW;
                    end
                    for (int j = 0; j < LETTERS; j++) begin
                        if (IDX_W'(j) == hit_j) used_d[j] = 1'b1;
                    end
                end
                // Yellow never touches greens, so the win flag can come from result_q here
                if (idx_q == IDX_W'(LETTERS - 1)) begin
                    busy_d      = 1'b0;
                    done_d      = 1'b1;
                    row_d       = (row_q < ROW_MAX) ? row_q + ROW_W'(1) : row_q;
                    win_d       = all_green;
                    game_over_d = all_green || (row_d == ROW_MAX);
                    state_d     = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register with synchronous clear
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q     <= IDLE;
            guess_q     <= '0;
            target_q    <= '0;
            result_q    <= '0;
            used_q      <= '0;
            idx_q       <= '0;
            row_q       <= '0;
            win_q       <= 1'b0;
            game_over_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            start_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            guess_q     <= guess_d;
            target_q    <= target_d;
            result_q    <= result_d;
            used_q      <= used_d;
            idx_q       <= idx_d;
            row_q       <= row_d;
            win_q       <= win_d;
            game_over_q <= game_over_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            start_q     <= start_d;
        end
    end

    assign result    = result_q;
    assign done      = done_q;
    assign busy      = busy_q;
    assign row       = row_q;
    assign win       = win_q;
    assign game_over = game_over_q;

endmodule

// File: tb/tb_guess_checker.sv
// Bench for guess_checker: fixed word table, hand-written multi-cycle sequences and random
// games scored by a letter-count reference model.
module tb_guess_checker;
    localparam int MAXG = 6;
    localparam logic [9:0] ALL_GREEN = 10'b10_10_10_10_10;

    logic        clk = 1'b0;
    logic        clr;
    logic        start;
    logic [24:0] guess;
    logic [24:0] target;
    logic [9:0]  result;
    logic        done;
    logic        busy;
    logic [2:0]  row;
    logic        win;
    logic        game_over;

    int   n_checks = 0;
    int   n_err = 0;
    int   m_row;
    logic m_win;
    logic m_go;

    typedef struct {
        logic [24:0] t;
        logic [24:0] g;
        logic [9:0]  res;
        logic        win;
    } vec_t;

    vec_t tbl[6];

    guess_checker #(.MAX_GUESSES(MAXG)) dut (
        .clk       (clk),
        .clr       (clr),
        .start     (start),
        .guess     (guess),
        .target    (target),
        .result    (result),
        .done      (done),
        .busy      (busy),
        .row       (row),
        .win       (win),
        .game_over (game_over)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    function automatic logic [24:0] word(input string s);
        logic [24:0] w;
        w = '0;
        for (int i = 0; i < 5; i++) w[5*i +: 5] = 5'(s[i] - 8'd65);
        return w;
    endfunction

    // Greens first, then remaining target letters are handed out left to right by count
    function automatic logic [9:0] model_result(input logic [24:0] g, input logic [24:0] t);
        int          cnt[32];
        logic [9:0]  r;
        logic [4:0]  gl;
        logic [4:0]  tl;
        r = '0;
        for (int k = 0; k < 32; k++) cnt[k] = 0;
        for (int i = 0; i < 5; i++) begin
            gl = g[5*i +: 5];
            tl = t[5*i +: 5];
            if (gl == tl) r[2*i +: 2] = 2'b10;
            else cnt[tl]++;
        end
        for (int i = 0; i < 5; i++) begin
            gl = g[5*i +: 5];
            if (r[2*i +: 2] != 2'b10 && cnt[gl] > 0) begin
                r[2*i +: 2] = 2'b01;
                cnt[gl]--;
            end
        end
        return r;
    endfunction

    function automatic logic [24:0] rand_word();
        logic [24:0] w;
        for (int i = 0; i < 5; i++)
            w[5*i +: 5] = ($urandom_range(0, 5) == 0) ? 5'($urandom_range(26, 31))
                                                      : 5'($urandom_range(0, 4));
        return w;
    endfunction

    // Called at a negedge; returns at a negedge with clr low
    task automatic do_clr();
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        m_row = 0;
        m_win = 1'b0;
        m_go  = 1'b0;
    endtask

    // One submitted guess; inputs are scrambled while busy to show they were latched
    task automatic do_guess(input logic [24:0] g, input logic [24:0] t, output logic [9:0] seen);
        logic [9:0] exp_res;
        logic       exp_win;
        int         lat;
        int         nbusy;
        int         stray;
        exp_res = model_result(g, t);
        exp_win = (exp_res == ALL_GREEN);
        seen    = '0;
        guess   = g;
        target  = t;
        start   = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        guess  = 25'($urandom);
        target = 25'($urandom);
        if (m_go) begin
            stray = 0;
            for (int c = 0; c < 10; c++) begin
                if (busy || done) stray++;
                @(negedge clk);
            end
            chk("ignored_start_activity", stray, 0);
            chk("ignored_start_row", int'(row), m_row);
            return;
        end
        lat   = 0;
        nbusy = 0;
        for (int c = 1; c <= 12; c++) begin
            if (done) begin
                lat = c;
                break;
            end
            if (busy) nbusy++;
            @(negedge clk);
        end
        chk("done_latency", lat, 7);
        chk("busy_cycles", nbusy, 6);
        if (lat == 0) return;
        m_row = (m_row < MAXG) ? m_row + 1 : m_row;
        m_win = exp_win;
        m_go  = exp_win || (m_row == MAXG);
        seen  = result;
        chk("result", int'(result), int'(exp_res));
        chk("busy_at_done", int'(busy), 0);
        chk("row", int'(row), m_row);
        chk("win", int'(win), int'(m_win));
        chk("game_over", int'(game_over), int'(m_go));
        @(negedge clk);
        chk("done_single_pulse", int'(done), 0);
        chk("result_hold", int'(result), int'(exp_res));
    endtask

    initial begin
        logic [9:0]  seen;
        logic [24:0] g;
        logic [24:0] t;
        int          pulses;

        tbl[0] = '{t: word("CRANE"), g: word("CRANE"), res: 10'b10_10_10_10_10, win: 1'b1};
        tbl[1] = '{t: word("ABBEY"), g: word("BOBBY"), res: 10'b10_00_10_00_01, win: 1'b0};
        tbl[2] = '{t: word("CRANE"), g: word("ZZZZZ"), res: 10'b00_00_00_00_00, win: 1'b0};
        tbl[3] = '{t: word("CRANE"), g: word("NACRE"), res: 10'b10_01_01_01_01, win: 1'b0};
        tbl[4] = '{t: word("SPEED"), g: word("EERIE"), res: 10'b00_00_00_01_01, win: 1'b0};
        tbl[5] = '{t: word("ABCDE"), g: word("EDCBA"), res: 10'b01_01_10_01_01, win: 1'b0};

        clr    = 1'b1;
        start  = 1'b0;
        guess  = '0;
        target = '0;
        m_row  = 0;
        m_win  = 1'b0;
        m_go   = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_result", int'(result), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_row", int'(row), 0);
        chk("reset_win", int'(win), 0);
        chk("reset_game_over", int'(game_over), 0);
        clr = 1'b0;

        // clr wins over start in the same cycle
        clr    = 1'b1;
        start  = 1'b1;
        guess  = word("CRANE");
        target = word("CRANE");
        @(negedge clk);
        clr   = 1'b0;
        start = 1'b0;
        pulses = 0;
        for (int c = 0; c < 10; c++) begin
            if (busy || done) pulses++;
            @(negedge clk);
        end
        chk("clr_priority_activity", pulses, 0);

        for (int k = 0; k < 6; k++) begin
            do_clr();
            do_guess(tbl[k].g, tbl[k].t, seen);
            chk("tbl_result", int'(seen), int'(tbl[k].res));
            chk("tbl_win", int'(win), int'(tbl[k].win));
        end

        // Six misses exhaust the game; a seventh start is ignored
        do_clr();
        for (int k = 0; k < 6; k++) do_guess(word("ZZZZZ"), word("CRANE"), seen);
        chk("six_miss_game_over", int'(game_over), 1);
        chk("six_miss_row", int'(row), 6);
        do_guess(word("CRANE"), word("CRANE"), seen);
        chk("seventh_game_over", int'(game_over), 1);

        // clr in the middle of a check
        do_clr();
        guess  = word("CRANE");
        target = word("CRANE");
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        chk("midclr_busy", int'(busy), 0);
        chk("midclr_done", int'(done), 0);
        chk("midclr_result", int'(result), 0);
        chk("midclr_row", int'(row), 0);
        chk("midclr_win", int'(win), 0);
        chk("midclr_game_over", int'(game_over), 0);
        pulses = 0;
        for (int c = 0; c < 10; c++) begin
            if (done || busy) pulses++;
            @(negedge clk);
        end
        chk("midclr_no_activity", pulses, 0);
        m_row = 0;
        m_win = 1'b0;
        m_go  = 1'b0;
        do_guess(word("NACRE"), word("CRANE"), seen);

        // start held high for ten cycles gives one check
        do_clr();
        guess  = word("NACRE");
        target = word("CRANE");
        start  = 1'b1;
        pulses = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (done) pulses++;
        end
        start = 1'b0;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            if (done) pulses++;
        end
        chk("held_start_done_pulses", pulses, 1);
        chk("held_start_row", int'(row), 1);
        chk("held_start_result", int'(result), int'(model_result(word("NACRE"), word("CRANE"))));

        // Random games against the reference model
        do_clr();
        for (int n = 0; n < 80; n++) begin
            if (m_go || $urandom_range(0, 9) == 0) do_clr();
            g = rand_word();
            t = ($urandom_range(0, 5) == 0) ? g : rand_word();
            do_guess(g, t, seen);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/guess_checker.md
GUESS_CHECKER -- requirements
Module: guess_checker

Interface
REQ-001 SHALL have parameter MAX_GUESSES, default 6: number of guesses allowed per game.
REQ-002 SHALL have port clk, input, 1 bit: single master clock; all state changes on its rising edge.
REQ-003 SHALL have port clr, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port start, input, 1 bit: one-cycle pulse meaning "guess submitted".
REQ-005 SHALL have port guess, input, 25 bits: five 5-bit letter codes (A=0 .. Z=25); position 0 = guess[4:0] (leftmost letter).
REQ-006 SHALL have port target, input, 25 bits: secret word, same encoding as guess.
REQ-007 SHALL have port result, output, 10 bits: 2 bits per position, with position 0 = result[1:0]; 00 gray, 01 yellow, 10 green; 11 never driven.
REQ-008 SHALL have port done, output, 1 bit: one-cycle pulse marking result valid.
REQ-009 SHALL have port busy, output, 1 bit: a check is in progress.
REQ-010 SHALL have port row, output, 3 bits: count of completed guesses.
REQ-011 SHALL have port win, output, 1 bit: the last check produced all green.
REQ-012 SHALL have port game_over, output, 1 bit: win, or MAX_GUESSES guesses used.

Function
REQ-013 SHALL implement FSM states IDLE, GREEN, YELLOW, DONE.
REQ-014 IDLE: start=1 with game_over=0 SHALL latch guess and target, clear the used[4:0] flags and all result bits to gray, and go to GREEN; busy=1 from the next cycle.
REQ-015 start SHALL be ignored while busy=1 or game_over=1.
REQ-016 GREEN (1 cycle): every position with guess[i]==target[i] SHALL be marked green and set used[i]; the yellow index SHALL be set to 0; the FSM SHALL go to YELLOW.
REQ-017 YELLOW (exactly 5 cycles, index i=0..4, one position per cycle): a non-green position i SHALL search for the lowest j with used[j]=0 and target[j]==guess[i].
REQ-018 On a hit, position i SHALL be marked yellow and used[j] set; on a miss it SHALL stay gray; one target letter SHALL never credit more than one guess letter.
REQ-019 After index 4 the FSM SHALL go to DONE.
REQ-020 DONE (1 cycle) SHALL assert done=1 and deassert busy, increment row (saturating at MAX_GUESSES), set win if all five positions are green, set game_over if win or row reaches MAX_GUESSES, then return to IDLE.
REQ-021 Latency SHALL be fixed: done is high in the 7th cycle after the edge that samples start; busy is high for the 6 cycles before it.
REQ-022 result SHALL hold its value from DONE until the next accepted start or reset.
REQ-023 Letter codes 26-31 SHALL compare by plain equality: no error flag and no special handling.
REQ-024 Changes on guess or target while busy=1 SHALL have no effect, because both are latched at start.
REQ-025 start asserted in the DONE cycle SHALL be ignored; start is accepted only in IDLE.

Reset
REQ-026 clr=1 SHALL, on the next rising edge and from any state including mid-check, force IDLE and set result=0, done=0, busy=0, row=0, win=0, game_over=0, used=0.
REQ-027 clr SHALL take priority over start in the same cycle.
REQ-028 After clr deasserts, a start in the following cycle SHALL be accepted.

Verification
REQ-029 target CRANE, guess CRANE, start -> done 7 cycles later, result=10_10_10_10_10, win=1, game_over=1, row=1.
REQ-030 target ABBEY, guess BOBBY -> result positions 0..4 = yellow, gray, green, gray, green.
REQ-031 target CRANE, guess ZZZZZ, six checks -> each done with result=0, row=1..6, game_over=1 after the sixth; a seventh start gives no busy and no done.
REQ-032 clr pulsed 3 cycles after start -> no done pulse, all outputs 0, FSM in IDLE; a new start then completes normally.
REQ-033 start held high for 10 cycles -> exactly one check, done pulses once, row=1.
REQ-034 guess changed during busy -> result matches the value latched at start.
